// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    VALID,
    EXEC
  } fetch_state_t;

  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [31:0] NOP_INS          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Multicycle instruction fetch: one AXI4-Lite read per instruction,
// handed to decode over valid/ready, then waits for the next PC.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dnpc,
  input  logic             pc_update,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      ins,
  output logic             valid,
  input  logic             ready,
  output logic             fetch_err,
  output logic [WIDTH-1:0] araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ins_q, ins_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: state_d = AR;
      AR: begin
        if (arready) state_d = R;
      end
      R: begin
        if (rvalid) begin
          ins_d   = rdata;
          err_d   = (rresp != AXI_RESP_OKAY);
          state_d = VALID;
        end
      end
      VALID: begin
        if (ready) state_d = EXEC;
      end
      EXEC: begin
        if (pc_update) begin
          pc_d    = dnpc;
          state_d = AR;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs follow the next state so they are flop outputs.
    valid_d   = (state_d == VALID);
    arvalid_d = (state_d == AR);
    rready_d  = (state_d == R);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ins_q     <= NOP_INS;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign pc        = pc_q;
  assign araddr    = pc_q;
  assign ins       = ins_q;
  assign fetch_err = err_q;
  assign valid     = valid_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table of fetch scenarios, random fetches
// against a transaction-level model, and a reset-during-read case.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dnpc;
  logic        pc_update;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        valid;
  logic        ready;
  logic        fetch_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  ifu_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .dnpc      (dnpc),
    .pc_update (pc_update),
    .pc        (pc),
    .ins       (ins),
    .valid     (valid),
    .ready     (ready),
    .fetch_err (fetch_err),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          aw;
    int          rw;
    logic [1:0]  resp;
    int          hold;
    bit          drop;
    int          ewait;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t v[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Acts as the AXI slave from the cycle after a PC is handed over
  // until valid rises; returns cycles taken and the address fetched.
  task automatic run_fetch(input int aw, input int rw,
                           input logic [1:0] resp,
                           output int lat, output logic [31:0] addr);
    int  cyc = 0;
    int  ac  = 0;
    int  rc  = 0;
    bit  ar_done = 0;
    bit  r_done  = 0;
    lat  = -1;
    addr = 32'hxxxx_xxxx;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      pc_update = 1'b0;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rdata     = $urandom;
      rresp     = 2'($urandom_range(0, 3));
      if (valid) begin
        lat = cyc;
        break;
      end
      if (!ar_done) chk("rready_early", 32'(rready), 0);
      if (ar_done) chk("ar_again", 32'(arvalid), 0);
      if (arvalid && !ar_done) begin
        if (ac == 0) addr = araddr;
        else chk("araddr_stable", araddr, addr);
        if (ac == aw) begin
          arready = 1'b1;
          ar_done = 1'b1;
        end
        ac++;
      end else if (rready && !r_done) begin
        if (rc == rw) begin
          rvalid = 1'b1;
          rdata  = mem_word(addr);
          rresp  = resp;
          r_done = 1'b1;
        end
        rc++;
      end
    end
    arready = 1'b0;
    rvalid  = 1'b0;
  endtask

  // Holds the presented word under backpressure with noise on ignored
  // inputs, accepts it, idles in execute, then hands over npc.
  task automatic present(input logic [31:0] epc, input logic [31:0] eins,
                         input bit eerr, input int hold, input bit drop,
                         input int ewait, input logic [31:0] npc);
    for (int i = 0; i <= hold; i++) begin
      chk("valid_hold", 32'(valid), 1);
      chk("pc", pc, epc);
      chk("ins", ins, eins);
      chk("fetch_err", 32'(fetch_err), 32'(eerr));
      chk("no_ar_valid", 32'(arvalid), 0);
      ready     = (i == hold);
      pc_update = (i == hold) ? drop : 1'($urandom_range(0, 1));
      dnpc      = $urandom;
      rvalid    = 1'($urandom_range(0, 1));
      arready   = 1'($urandom_range(0, 1));
      rdata     = $urandom;
      @(posedge clk); #1;
    end
    ready     = 1'b0;
    pc_update = 1'b0;
    for (int i = 0; i < ewait; i++) begin
      chk("exec_valid", 32'(valid), 0);
      chk("exec_noar", 32'(arvalid), 0);
      rvalid  = 1'($urandom_range(0, 1));
      arready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("exec_valid", 32'(valid), 0);
    chk("exec_ins", ins, eins);
    pc_update = 1'b1;
    dnpc      = npc;
    rvalid    = 1'b0;
    arready   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_ins"}, ins, NOP);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_err"}, 32'(fetch_err), 0);
    chk({tag, "_arvalid"}, 32'(arvalid), 0);
    chk({tag, "_araddr"}, araddr, RST_PC);
    chk({tag, "_rready"}, 32'(rready), 0);
  endtask

  initial begin
    int          lat;
    logic [31:0] addr;
    logic [31:0] nxt;
    logic [31:0] cur;
    int          aw, rw, hold, ewait;
    logic [1:0]  resp;
    bit          drop;

    v[0] = '{32'h8000_0000, 0, 0, 2'b00, 0,  1'b0, 0, 3, 1'b0};
    v[1] = '{32'h8000_0004, 3, 2, 2'b00, 10, 1'b1, 2, 8, 1'b0};
    v[2] = '{32'h8000_0100, 0, 0, 2'b10, 2,  1'b0, 1, 3, 1'b1};
    v[3] = '{32'h8000_0103, 1, 0, 2'b00, 0,  1'b0, 0, 4, 1'b0};
    v[4] = '{32'h8000_0200, 0, 1, 2'b11, 1,  1'b1, 1, 4, 1'b1};
    v[5] = '{32'h1234_5678, 2, 2, 2'b01, 0,  1'b0, 3, 7, 1'b1};

    rst = 1'b1; dnpc = '0; pc_update = 1'b0; ready = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_fetch(v[i].aw, v[i].rw, v[i].resp, lat, addr);
      chk("latency", 32'(lat), 32'(v[i].exp_lat));
      chk("araddr", addr, v[i].pc);
      nxt = (i < 5) ? v[i+1].pc : 32'h8000_1000;
      present(v[i].pc, mem_word(v[i].pc), v[i].exp_err, v[i].hold,
              v[i].drop, v[i].ewait, nxt);
    end

    cur = nxt;
    for (int i = 0; i < 40; i++) begin
      aw    = $urandom_range(0, 4);
      rw    = $urandom_range(0, 4);
      resp  = 2'($urandom_range(0, 3));
      hold  = $urandom_range(0, 3);
      drop  = 1'($urandom_range(0, 1));
      ewait = $urandom_range(0, 3);
      nxt   = $urandom;
      run_fetch(aw, rw, resp, lat, addr);
      chk("rnd_latency", 32'(lat), 32'(3 + aw + rw));
      chk("rnd_araddr", addr, cur);
      present(cur, mem_word(cur), resp != 2'b00, hold, drop, ewait, nxt);
      cur = nxt;
    end

    @(posedge clk); #1;
    pc_update = 1'b0;
    chk("pre_rst_arvalid", 32'(arvalid), 1);
    chk("pre_rst_araddr", araddr, cur);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("pre_rst_rready", 32'(rready), 1);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    rresp  = 2'b10;
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async");
    rvalid = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("held");
    rst = 1'b0;
    run_fetch(0, 0, 2'b00, lat, addr);
    chk("restart_lat", 32'(lat), 3);
    chk("restart_addr", addr, RST_PC);
    chk("restart_ins", ins, 32'h0000_0413);
    chk("restart_pc", pc, RST_PC);
    chk("restart_err", 32'(fetch_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage for the multicycle RV32 core. Holds the architectural PC, issues one AXI4-Lite read per instruction, and presents the fetched word to the decode stage over a valid/ready handshake. It then waits for the write-back stage to supply the next PC before fetching again. It sits directly upstream of the decoder and replaces the fixed-latency fetch with a bus-tolerant one.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- WIDTH, 32, address and data width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- dnpc  in  WIDTH  next PC computed downstream.
- pc_update  in  1  one-cycle pulse; dnpc is valid and the current instruction has retired.
- pc  out  WIDTH  PC of the instruction in `ins`.
- ins  out  32  fetched instruction word.
- valid  out  1  `ins`/`pc` valid toward decode.
- ready  in  1  decode accepts.
- fetch_err  out  1  the presented instruction returned a non-OKAY response.
- araddr  out  WIDTH  AR address.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rdata  in  32  R data.
- rresp  in  2  R response.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

## Operation
- States: IDLE, AR, R, VALID, EXEC.
- IDLE: entered on reset. Unconditionally goes to AR on the next clock.
- AR: arvalid=1, araddr=pc. Goes to R when arvalid&&arready. araddr is held stable while arready=0.
- R: rready=1. When rvalid: ins<=rdata, fetch_err<=(rresp!=2'b00), go to VALID.
- VALID: valid=1; ins, pc and fetch_err are held stable. Goes to EXEC on valid&&ready.
- EXEC: valid=0. When pc_update=1: pc<=dnpc, go to AR.
- pc_update is ignored in every state except EXEC.
- rvalid is ignored outside R. arready is ignored outside AR.
- Error handling: a non-OKAY response is still delivered as a normal instruction with fetch_err=1. Trap handling is done downstream. fetch_err clears on the next R beat.
- dnpc is accepted unaligned and unmodified. Alignment is checked downstream.

## Timing
- Reset values: pc=RESET_PC, ins=32'h0000_0013 (nop), valid=0, fetch_err=0, arvalid=0, araddr=RESET_PC, rready=0, state=IDLE.
- Reset is asserted asynchronously and deasserted synchronously by the system. Reset in any state returns the block to IDLE immediately, and any in-flight AXI transaction is abandoned. The bus slave shares the same reset.
- Minimum fetch latency, with arready and rvalid each high on first assertion:
  - pc_update sampled in cycle n.
  - arvalid high in n+1.
  - rready high in n+2 with rvalid.
  - valid high in n+3.
- First fetch after reset: arvalid in the 2nd cycle after rst falls; valid in the 4th cycle.
- Backpressure: valid stays high indefinitely while ready=0. AR and R wait states extend their states cycle for cycle, with no limit.
- If valid&&ready and pc_update occur in the same cycle, the pc_update is dropped (the state is VALID, not EXEC).
- arvalid and rready are registered outputs, decoded from the state register only. There is no combinational path from any input to any output.

## Structure
- Shared package ifu_pkg:
  - fetch_state_t enum {IDLE, AR, R, VALID, EXEC};
  - AXI_RESP_OKAY=2'b00;
  - NOP_INS=32'h0000_0013;
  - DEFAULT_RESET_PC.
- Single module with no sub-modules. The AXI4-Lite read master is small enough to live inline.

## Test plan
- Reset release, slave with zero wait states, mem[8000_0000]=32'h00000413 -> araddr=8000_0000 with arvalid in cycle 2; valid with ins=00000413, pc=8000_0000 in cycle 4.
- arready delayed 3 cycles, rvalid delayed 2 -> araddr stable throughout; valid asserted exactly 5 cycles later than the zero-wait case; ins correct.
- ready held 0 for 10 cycles in VALID -> valid, ins and pc stable; no new AR issued; pc_update pulses during VALID are ignored.
- EXEC, then pc_update with dnpc=8000_0100 -> next araddr=8000_0100, and pc=8000_0100 when valid.
- rresp=2'b10 on a fetch -> valid with fetch_err=1; the next fetch with OKAY returns fetch_err=0.
- rst asserted while in R with a pending rvalid -> outputs take reset values in the same cycle; after release the fetch restarts at RESET_PC.
